cic_integ_decim: RTL
====================

// Module: cic_integ_decim
// PURPOSE
//  Front half of the CIC decimator: NUM_STAGES cascaded integrators at input rate plus a programmable-ratio downsampler.
//  Sits directly upstream of the comb chain; out_valid drives the combs' en, out_data feeds the first comb's in.
//  Integrators run full accumulator width with modular (wrap-around) arithmetic; the comb chain cancels the wrap.
// PARAMETERS
//  DATA_WIDTH  16  input sample width, signed two's complement
//  NUM_STAGES  3   number of integrator stages (>=1)
//  MAX_R       16  largest decimation ratio supported
//  ACC_WIDTH   DATA_WIDTH+NUM_STAGES*$clog2(MAX_R)  accumulator/output width (derived, do not override)
//  RW          $clog2(MAX_R+1)  width of ratio port (derived)
// PORTS
//  clk        in   1           clock, all logic on rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           input sample strobe, one sample per high cycle
//  in_data    in   DATA_WIDTH  signed input sample
//  ratio      in   RW          decimation ratio R; 0 treated as 1, >MAX_R clamped to MAX_R
//  out_valid  out  1           one-cycle pulse per decimated sample; connects to comb en
//  out_data   out  ACC_WIDTH   signed last-integrator value; held between pulses
//  sync       in   1           only present when CIC_DECIM_SYNC_EN is defined
// BEHAVIOUR
//  Reset: integ[0..NUM_STAGES-1]=0, cnt=0, ratio_q=1, out_valid=0, out_data=0.
//  Integrators update only when in_valid=1; else all hold:
//   integ[0] <= integ[0] + sext(in_data); integ[k] <= integ[k] + integ[k-1] (old value), k>=1.
//   Sums truncate to ACC_WIDTH (mod 2^ACC_WIDTH); no saturation, no overflow flag.
//  Ratio: eff_r = clamp(ratio) when cnt==0, else ratio_q; ratio_q <= clamp(ratio) on in_valid&&cnt==0.
//   A ratio change mid-frame takes effect at the next frame start only.
//  Counter: on in_valid, if cnt==eff_r-1 then cnt<=0 (terminal) else cnt<=cnt+1.
//  Output: on terminal in_valid cycle, next edge sets out_valid<=1 and out_data<=updated integ[NUM_STAGES-1].
//   Latency: out_valid high the cycle after the R-th accepted sample; low otherwise.
//   R=1: out_valid mirrors in_valid delayed one cycle; every sample emitted.
//  in_valid gaps: counter and integrators freeze; frame continues when samples resume.
//  Reset mid-frame: all state cleared immediately; partial frame discarded, no out_valid.
// CONFIGURATION
//  CIC_DECIM_SYNC_EN defined: sync port exists; sync=1 forces cnt<=0 and ratio_q<=clamp(ratio), suppresses
//   out_valid that cycle even if terminal; a coincident in_valid sample is still integrated but not counted.
//   Integrators never cleared by sync. Used to phase-align parallel channels.
//  Undefined: no sync port, no related logic; frame phase set by reset only.
// STRUCTURE
//  Package cic_pkg: ACC_WIDTH/RW derivation functions, clamp_ratio function, acc_t signed typedef.
//  Sub-module cic_integrator: one stage (en, signed in, registered acc); generate loop instantiates NUM_STAGES.
//  Top holds counter, ratio_q, output register, optional sync logic.
// TESTING
//  NUM_STAGES=1, ratio=4, in_data=1 every cycle -> out_valid every 4th cycle, out_data 4,8,12,16.
//  Defaults, ratio=1, impulse 1 then zeros -> out_valid each sample; out_data 0,0,1,3,6,10 (integ[2] after samples 0..5).
//  Defaults, in_data=32767 constant, ratio=16, 100k samples -> integrators wrap mod 2^28; comb-chain golden matches.
//  ratio 4->2 written after 2nd sample of a frame -> that frame ends at sample 4; next frame is 2 samples.
//  in_valid toggling 1010..., ratio=3 -> out_valid after 3rd accepted sample (cycle 6); rst_n low mid-frame clears all.
//  CIC_DECIM_SYNC_EN, ratio=4, sync at cnt=2 -> no out_valid; next out_valid after 4 more samples.

Source files
------------

// File: rtl/cic_pkg.sv
// Shared width derivations, ratio clamping and the default accumulator type for the CIC integrator front end.
package cic_pkg;

  function automatic int unsigned acc_width(int unsigned dw, int unsigned ns, int unsigned max_r);
    return dw + ns * $clog2(max_r);
  endfunction

  function automatic int unsigned ratio_width(int unsigned max_r);
    return $clog2(max_r + 1);
  endfunction

  // Ratio 0 behaves as 1; anything above max_r saturates to max_r.
  function automatic int unsigned clamp_ratio(int unsigned r, int unsigned max_r);
    if (r == 0) return 1;
    if (r > max_r) return max_r;
    return r;
  endfunction

  localparam int unsigned DEF_ACC_WIDTH = acc_width(16, 3, 16);

  typedef logic signed [DEF_ACC_WIDTH-1:0] acc_t;

endpackage

// File: rtl/cic_integrator.sv
// One wrap-around integrator stage; acc_nxt_c exposes the value the accumulator takes on the next enabled edge.
module cic_integrator #(
  parameter int unsigned W = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic signed [W-1:0] in_data,
  output logic signed [W-1:0] acc_q,
  output logic signed [W-1:0] acc_nxt_c
);

  logic signed [W-1:0] acc_d;

  always_comb begin
    acc_nxt_c = acc_q + in_data;
    acc_d     = acc_q;
    if (en) acc_d = acc_nxt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/cic_integ_decim.sv
// CIC decimator front half: cascaded integrators plus a programmable-ratio downsampler.
// Define CIC_DECIM_SYNC_EN to add the sync port that restarts the decimation frame.
module cic_integ_decim
  import cic_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned MAX_R      = 16,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, NUM_STAGES, MAX_R),
  parameter int unsigned RW         = ratio_width(MAX_R)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic [RW-1:0]               ratio,
  output logic                        out_valid,
  output logic signed [ACC_WIDTH-1:0] out_data
`ifdef CIC_DECIM_SYNC_EN
  ,
  input  logic                        sync
`endif
);

  logic signed [ACC_WIDTH-1:0] stage_in [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] acc      [NUM_STAGES];
  logic signed [ACC_WIDTH-1:0] acc_nxt  [NUM_STAGES];

  assign stage_in[0] = ACC_WIDTH'(in_data);

  // Each stage adds the previous stage's pre-update value.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign stage_in[k] = acc[k-1];
    end
    cic_integrator #(.W(ACC_WIDTH)) u_integ (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (in_valid),
      .in_data   (stage_in[k]),
      .acc_q     (acc[k]),
      .acc_nxt_c (acc_nxt[k])
    );
  end

  logic [RW-1:0]               cnt_q, cnt_d;
  logic [RW-1:0]               ratio_q, ratio_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic [RW-1:0]               ratio_cl;
  logic [RW-1:0]               eff_r;
  logic                        term;

  // The ratio is sampled only at frame start so a mid-frame change waits for the next frame.
  always_comb begin
    ratio_cl    = RW'(clamp_ratio(32'(ratio), MAX_R));
    eff_r       = (cnt_q == '0) ? ratio_cl : ratio_q;
    term        = in_valid && (cnt_q == eff_r - RW'(1));
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (in_valid) begin
      cnt_d = term ? '0 : cnt_q + RW'(1);
      if (cnt_q == '0) ratio_d = ratio_cl;
      if (term) begin
        out_valid_d = 1'b1;
        out_data_d  = acc_nxt[NUM_STAGES-1];
      end
    end
`ifdef CIC_DECIM_SYNC_EN
    // Sync restarts the frame; a coincident sample still integrates but is not counted.
    if (sync) begin
      cnt_d       = '0;
      ratio_d     = ratio_cl;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      ratio_q     <= RW'(1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
